// File: rtl/tone_scheduler.sv
// Note sequencer for the square-wave tone generator: FIFO of (freq, dur) entries, tick prescaler, play FSM.
// Optional inter-note silence is compiled in with `define TONE_SCHED_GAP_EN.
module tone_scheduler #(
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 48000,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [31:0]              wr_freq,
  input  logic [15:0]              wr_dur,
  input  logic                     flush,
  output logic [31:0]              out_freq,
  output logic                     gen_en,
  output logic                     busy,
  output logic                     note_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PEN  = (TICK_DIV >= 2) ? TW'(TICK_DIV - 2) : '0;

`ifdef TONE_SCHED_GAP_EN
  localparam bit GAP_ON = (GAP_TICKS > 0);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_TICKS - 1);
`else
  localparam bit GAP_ON = 1'b0 & (GAP_TICKS > 0);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PLAY
`ifdef TONE_SCHED_GAP_EN
    , GAP
`endif
  } state_t;

  state_t        state;
  logic [31:0]   freq_mem [DEPTH];
  logic [15:0]   dur_mem  [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   dur_cnt;
`ifdef TONE_SCHED_GAP_EN
  logic [15:0]   gap_cnt;
  logic          gap_end;
`endif

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        note_end;
  logic        seq_free;
  logic        go_gap;
  logic [31:0] head_freq;
  logic [15:0] head_dur;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign level     = wr_ptr - rd_ptr;
  assign wr_ready  = !full && !flush;
  assign push      = wr_valid && wr_ready;
  assign head_freq = freq_mem[rd_ptr[AW-1:0]];
  assign head_dur  = dur_mem[rd_ptr[AW-1:0]];

  assign note_end = (state == PLAY) && (tick_cnt == TICK_LAST) && (dur_cnt == '0);
  assign go_gap   = note_end && GAP_ON;
`ifdef TONE_SCHED_GAP_EN
  assign gap_end  = (state == GAP) && (tick_cnt == TICK_LAST) && (gap_cnt == '0);
  assign seq_free = (state == IDLE) || (note_end && !GAP_ON) || gap_end;
`else
  assign seq_free = (state == IDLE) || note_end;
`endif
  // The sequencer may only take a new entry when idle or on the final cycle of a note/gap.
  assign pop = seq_free && !empty && !flush;

  always_ff @(posedge clock) begin
    if (push) begin
      freq_mem[wr_ptr[AW-1:0]] <= wr_freq;
      dur_mem[wr_ptr[AW-1:0]]  <= wr_dur;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // note_done is registered, so it is raised on the edge that enters the last cycle of a note.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
`ifdef TONE_SCHED_GAP_EN
      gap_cnt   <= '0;
`endif
      out_freq  <= '0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
      out_freq  <= '0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
    end else begin
      note_done <= 1'b0;
      if (pop) begin
        state     <= PLAY;
        rd_ptr    <= rd_ptr + 1'b1;
        tick_cnt  <= '0;
        dur_cnt   <= (head_dur == '0) ? '0 : head_dur - 16'd1;
        out_freq  <= head_freq;
        gen_en    <= (head_freq != '0);
        busy      <= 1'b1;
        note_done <= (TICK_DIV == 1) && (head_dur <= 16'd1);
      end else if (seq_free) begin
        state    <= IDLE;
        tick_cnt <= '0;
        out_freq <= '0;
        gen_en   <= 1'b0;
        busy     <= 1'b0;
      end else if (go_gap) begin
`ifdef TONE_SCHED_GAP_EN
        state    <= GAP;
        tick_cnt <= '0;
        gap_cnt  <= GAP_LOAD;
        out_freq <= '0;
        gen_en   <= 1'b0;
        busy     <= 1'b1;
`endif
      end else if (state == PLAY) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt  <= '0;
          dur_cnt   <= dur_cnt - 16'd1;
          note_done <= (TICK_DIV == 1) && (dur_cnt == 16'd1);
        end else begin
          tick_cnt  <= tick_cnt + 1'b1;
          note_done <= (tick_cnt == TICK_PEN) && (dur_cnt == '0);
        end
      end
`ifdef TONE_SCHED_GAP_EN
      else if (state == GAP) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          gap_cnt  <= gap_cnt - 16'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
